// File: rtl/cpu5_dmem_resp.sv
// cpu5_dmem_resp: the memory-side responder of the cpu5 load/store port.
// It accepts one request at a time and waits a fixed number of cycles.
// It then commits the access to a word RAM and returns a response over a
// valid/ready channel.
//
// Ports:
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_addr          byte address; word index = addr[log2(DEPTH)+1:2]
//   req_wdata/wstrb   lane-aligned store data and byte enables
//   resp_valid/ready  response handshake; the response is held until accepted
//   resp_rdata        load data (0 for stores and errored accesses)
//   resp_err          access error; tied 0 unless CPU5_DMEM_ERR_EN is defined
//
// Optional feature (macro CPU5_DMEM_ERR_EN): a misaligned address or an
// address with nonzero bits above the index is flagged as an error. An
// errored access does not write the RAM and returns zero data.
module cpu5_dmem_resp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WAIT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_wstrb,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CNTW = 4;
  localparam logic [CNTW-1:0] WAIT_CNT = CNTW'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            accept_c;
  logic            commit_c;

  logic            lat_we;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [3:0]      lat_wstrb;

  logic            acc_we;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [3:0]      acc_wstrb;
  logic [IDXW-1:0] acc_idx;
  logic            acc_err;

  logic [XLEN-1:0] mem [DEPTH];

  // With WAIT=0 the commit happens on the accept edge, before the request is
  // latched, so the access fields come straight from the request port in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
    end
  end

  assign acc_idx = acc_addr[IDXW+1:2];

`ifdef CPU5_DMEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[XLEN-1:IDXW+2] != '0);
`else
  // Addresses alias onto the index bits; the remaining bits are deliberately unused.
  logic unused_addr;
  assign acc_err     = 1'b0;
  assign unused_addr = ^{acc_addr[XLEN-1:IDXW+2], acc_addr[1:0]};
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          cnt_n    = WAIT_CNT;
          if (WAIT == 0) begin
            state_n  = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          state_n  = ST_RESP;
          commit_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, handshake outputs, request latch and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      req_ready  <= (state_n == ST_IDLE);
      resp_valid <= (state_n == ST_RESP);
      if (accept_c) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
      end
      if (commit_c) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
      end
    end
  end

  // Byte-lane RAM write on the commit edge; RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (commit_c && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu5_dmem_resp.sv
// Testbench for cpu5_dmem_resp. It uses two instances: inst 0 with WAIT=2
// and inst 1 with WAIT=0. The stimulus pushes each expected response into a
// queue. A monitor pops and checks every response when the DUT presents it,
// including the latency and the stability of a held response.
module tb_cpu5_dmem_resp;

  logic        clk;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          seen   [2];
  logic [31:0] held_rdata [2];
  logic        held_err   [2];

`ifdef CPU5_DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  cpu5_dmem_resp #(.XLEN(32), .DEPTH(1024), .WAIT(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  cpu5_dmem_resp #(.XLEN(32), .DEPTH(1024), .WAIT(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int wait_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Monitor: checks each response when it first appears, and then checks that it holds.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        if (resp_valid[k]) begin
          if (!seen[k]) begin
            if (sbq.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_resp: port %0d rdata %h with empty queue", k, resp_rdata[k]);
            end else begin
              mon_e = sbq.pop_front();
              chk("resp_port", 32'(k), 32'(mon_e.port));
              chk("resp_rdata", resp_rdata[k], mon_e.rdata);
              chk("resp_err", 32'(resp_err[k]), 32'(mon_e.err));
              chk("resp_latency", 32'(cyc), 32'(mon_e.due));
            end
            seen[k]       = 1'b1;
            held_rdata[k] = resp_rdata[k];
            held_err[k]   = resp_err[k];
          end else begin
            chk("held_rdata", resp_rdata[k], held_rdata[k]);
            chk("held_err", 32'(resp_err[k]), 32'(held_err[k]));
          end
          chk("req_ready_in_resp", 32'(req_ready[k]), 32'(0));
          if (resp_ready[k]) seen[k] = 1'b0;
        end else if (seen[k]) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_dropped: port %0d resp_valid fell without resp_ready", k);
          seen[k] = 1'b0;
        end
      end
    end else begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
    end
  end

  // Issue one request and queue its expected response. The task returns just after the accept edge.
  task automatic do_req(input int k, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    bit   done;
    n    = 0;
    done = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_wstrb[k] = st;
    while (!done) begin
      @(negedge clk);
      if (req_ready[k]) begin
        e.port  = k;
        e.rdata = er;
        e.err   = ee;
        e.due   = cyc + wait_of(k) + 1;
        sbq.push_back(e);
        done = 1'b1;
      end else if (++n > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: port %0d addr %h", k, a);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(sbq.size() == 0 && req_ready[k] && !resp_valid[k])) begin
      @(negedge clk);
      if (++n > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL idle_timeout: port %0d queue %0d", k, sbq.size());
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_req_ready", 32'(req_ready[k]), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid[k]), 32'(0));
    chk("rst_resp_rdata", resp_rdata[k], 32'h0);
    chk("rst_resp_err", 32'(resp_err[k]), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      req_wstrb[k]  = '0;
      resp_ready[k] = 1'b1;
      seen[k]       = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 1'b1;

    // 1: reset in the middle of a store's WAIT aborts the store.
    do_req(0, 1'b1, 32'h10, 32'h11111111, 4'hF, 32'h0, 1'b0);
    wait_idle(0);
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals(0);
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h11111111, 1'b0);
    wait_idle(0);

    // 2: full-word store, then a load of the same word.
    do_req(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // 3: byte-lane store, then a store with all strobes off.
    do_req(0, 1'b1, 32'h40, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h123456AA, 1'b0);
    do_req(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h123456AA, 1'b0);
    wait_idle(0);

    // 4: the response is back-pressured while a stray request is presented.
    resp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h123456AA, 1'b0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h40;
    req_wdata[0] = 32'h0;
    req_wstrb[0] = 4'hF;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("hold_req_ready", 32'(req_ready[0]), 32'(0));
    end
    chk("hold_resp_valid", 32'(resp_valid[0]), 32'(1));
    @(posedge clk); #1;
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    wait_idle(0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h123456AA, 1'b0);
    wait_idle(0);

    // 5: WAIT=0 instance; an address at the DEPTH boundary wraps (or is an error).
    do_req(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    do_req(1, 1'b0, 32'h1000, 32'h0, 4'h0, ERR ? 32'h0 : 32'hCAFEF00D, ERR);

    // 6: misaligned load and out-of-range store.
    do_req(1, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
    do_req(1, 1'b0, 32'h42, 32'h0, 4'h0, ERR ? 32'h0 : 32'h55AA55AA, ERR);
    do_req(1, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF, 32'h0, ERR);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, ERR ? 32'hCAFEF00D : 32'h0BADF00D, 1'b0);
    wait_idle(1);

    chk("queue_empty", 32'(sbq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
